// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and constants for the score keeper and display decoder
package score_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    JUDGE = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam int DEF_MAX_SCORE = 4;
  localparam int TALLY_W       = 3;

  // Saturating increment; the FSM never asks for one at the ceiling.
  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v,
                                                 input logic [TALLY_W-1:0] max);
    return (v >= max) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - player inputs and scoring outputs of the score keeper
interface score_keeper_if
  import score_pkg::*;
#(
  parameter int GUESS_W = 4
);

  logic               submit;
  logic               new_game;
  logic [GUESS_W-1:0] guess;
  logic [GUESS_W-1:0] target;
  logic [TALLY_W-1:0] right;
  logic [TALLY_W-1:0] wrong;
  logic               hit;
  logic               miss;
  logic               next_req;
  logic               game_over;
  logic               win;

  modport master (
    output submit, new_game, guess, target,
    input  right, wrong, hit, miss, next_req, game_over, win
  );

  modport slave (
    input  submit, new_game, guess, target,
    output right, wrong, hit, miss, next_req, game_over, win
  );

endinterface

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - 2-flop synchronizer plus rising-edge pulse, all flops reset to 1
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  // Reset-to-1 means a button held through reset must be released before it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - judges guesses against the target and keeps right/wrong tallies
module score_keeper
  import score_pkg::*;
#(
  parameter int GUESS_W   = 4,
  parameter int MAX_SCORE = DEF_MAX_SCORE
) (
  input logic           clk,
  input logic           rst_n,
  score_keeper_if.slave bus
);

  localparam logic [TALLY_W-1:0] MAX_T = TALLY_W'(MAX_SCORE);

  state_t             state;
  logic               sub_pulse;
  logic               match;
  logic [TALLY_W-1:0] right_q;
  logic [TALLY_W-1:0] wrong_q;
  logic [TALLY_W-1:0] cur_tally;
  logic [TALLY_W-1:0] next_tally;
  logic               hit_q;
  logic               miss_q;
  logic               next_req_q;
  logic               game_over_q;
  logic               win_q;
  logic [GUESS_W-1:0] guess_s;
  logic [GUESS_W-1:0] target_s;

  assign guess_s  = bus.guess;
  assign target_s = bus.target;

  btn_sync_edge u_submit_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.submit),
    .pulse (sub_pulse)
  );

  assign cur_tally  = match ? right_q : wrong_q;
  assign next_tally = sat_inc(cur_tally, MAX_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLAY;
      match       <= 1'b0;
      right_q     <= '0;
      wrong_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      next_req_q  <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else if (bus.new_game) begin
      // Restart wins over everything, including a judgment completing this cycle.
      state       <= PLAY;
      right_q     <= '0;
      wrong_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      next_req_q  <= 1'b1;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      next_req_q <= 1'b0;
      case (state)
        PLAY: begin
          if (sub_pulse) begin
            match <= (guess_s == target_s);
            state <= JUDGE;
          end
        end
        JUDGE: begin
          if (match) begin
            right_q <= next_tally;
            hit_q   <= 1'b1;
          end else begin
            wrong_q <= next_tally;
            miss_q  <= 1'b1;
          end
          next_req_q <= 1'b1;
          if (next_tally == MAX_T) begin
            state       <= OVER;
            game_over_q <= 1'b1;
            win_q       <= match;
          end else begin
            state <= PLAY;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  tally_below_max: assert property (@(posedge clk) disable iff (!rst_n)
    (state == JUDGE && !bus.new_game) |-> (cur_tally < MAX_T));

  assign bus.right     = right_q;
  assign bus.wrong     = wrong_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.next_req  = next_req_q;
  assign bus.game_over = game_over_q;
  assign bus.win       = win_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - randomized self-checking bench for score_keeper
module tb_score_keeper;
  import score_pkg::*;

  localparam int MAX = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   hit_cnt, miss_cnt, nreq_cnt, dbl_cnt;
  logic hit_prev, miss_prev, nreq_prev;
  int   m_right, m_wrong;
  bit   m_over;

  score_keeper_if #(.GUESS_W(4)) bus ();

  score_keeper #(.GUESS_W(4), .MAX_SCORE(MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    hit_cnt = 0; miss_cnt = 0; nreq_cnt = 0; dbl_cnt = 0;
    hit_prev = 0; miss_prev = 0; nreq_prev = 0;
  end

  always @(negedge clk) begin
    if (bus.hit === 1'b1) hit_cnt++;
    if (bus.miss === 1'b1) miss_cnt++;
    if (bus.next_req === 1'b1) nreq_cnt++;
    if ((bus.hit && hit_prev) || (bus.miss && miss_prev) || (bus.next_req && nreq_prev)) dbl_cnt++;
    hit_prev  = bus.hit;
    miss_prev = bus.miss;
    nreq_prev = bus.next_req;
  end

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_right = 0;
    m_wrong = 0;
    m_over  = 0;
  endtask

  task automatic do_reset();
    bus.submit = 1'b0; bus.new_game = 1'b0; bus.guess = '0; bus.target = '0;
    rst_n = 1'b0;
    repeat (3) wait_edge();
    rst_n = 1'b1;
    repeat (3) wait_edge();
    model_clear();
  endtask

  task automatic check_state(input string name);
    checks++;
    if (bus.right !== 3'(m_right) || bus.wrong !== 3'(m_wrong)) begin
      failures++;
      $display("FAIL %s tallies: got right=%0d wrong=%0d, want right=%0d wrong=%0d",
               name, bus.right, bus.wrong, m_right, m_wrong);
    end
    checks++;
    if (bus.game_over !== m_over || bus.win !== (m_over && m_right == MAX)) begin
      failures++;
      $display("FAIL %s over: got game_over=%b win=%b, want game_over=%b win=%b",
               name, bus.game_over, bus.win, m_over, m_over && m_right == MAX);
    end
  endtask

  task automatic press(input logic [3:0] g, input logic [3:0] t, input int hold, input string name);
    int  h0, mi0, n0;
    bit  judged;
    h0 = hit_cnt; mi0 = miss_cnt; n0 = nreq_cnt;
    judged = !m_over;
    if (judged) begin
      if (g == t) m_right++; else m_wrong++;
      m_over = (m_right == MAX) || (m_wrong == MAX);
    end
    bus.guess = g; bus.target = t; bus.submit = 1'b1;
    repeat (hold) wait_edge();
    bus.guess = 4'($urandom); bus.target = 4'($urandom);
    bus.submit = 1'b0;
    repeat (5) wait_edge();
    checks++;
    if (hit_cnt - h0 != int'(judged && g == t) || miss_cnt - mi0 != int'(judged && g != t)
        || nreq_cnt - n0 != int'(judged)) begin
      failures++;
      $display("FAIL %s pulses: got hit=%0d miss=%0d next_req=%0d, want hit=%0d miss=%0d next_req=%0d",
               name, hit_cnt - h0, miss_cnt - mi0, nreq_cnt - n0,
               int'(judged && g == t), int'(judged && g != t), int'(judged));
    end
    check_state(name);
  endtask

  task automatic do_new_game(input string name);
    bus.new_game = 1'b1;
    wait_edge();
    bus.new_game = 1'b0;
    model_clear();
    checks++;
    if (bus.right !== 3'd0 || bus.wrong !== 3'd0 || bus.game_over !== 1'b0 || bus.next_req !== 1'b1) begin
      failures++;
      $display("FAIL %s new_game: got right=%0d wrong=%0d game_over=%b next_req=%b, want 0 0 0 1",
               name, bus.right, bus.wrong, bus.game_over, bus.next_req);
    end
    wait_edge();
    checks++;
    if (bus.next_req !== 1'b0) begin
      failures++;
      $display("FAIL %s next_req_width: got %b, want 0", name, bus.next_req);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.right, bus.wrong, bus.hit, bus.miss, bus.next_req, bus.game_over, bus.win} !== 11'd0) begin
      failures++;
      $display("FAIL reset outputs: got %b, want all 0",
               {bus.right, bus.wrong, bus.hit, bus.miss, bus.next_req, bus.game_over, bus.win});
    end
  endtask

  task automatic test_latency();
    bus.guess = 4'd5; bus.target = 4'd5; bus.submit = 1'b1;
    repeat (3) wait_edge();
    checks++;
    if (bus.right !== 3'd0 || bus.hit !== 1'b0) begin
      failures++;
      $display("FAIL latency early: got right=%0d hit=%b after N+2, want 0 0", bus.right, bus.hit);
    end
    wait_edge();
    checks++;
    if (bus.right !== 3'd1 || bus.wrong !== 3'd0 || bus.hit !== 1'b1 || bus.miss !== 1'b0 || bus.next_req !== 1'b1) begin
      failures++;
      $display("FAIL latency judge: got right=%0d wrong=%0d hit=%b miss=%b next_req=%b, want 1 0 1 0 1",
               bus.right, bus.wrong, bus.hit, bus.miss, bus.next_req);
    end
    wait_edge();
    checks++;
    if (bus.hit !== 1'b0 || bus.next_req !== 1'b0) begin
      failures++;
      $display("FAIL latency pulse_width: got hit=%b next_req=%b, want 0 0", bus.hit, bus.next_req);
    end
    bus.submit = 1'b0;
    repeat (4) wait_edge();
    m_right = 1;
  endtask

  task automatic test_lose();
    do_new_game("lose");
    for (int i = 0; i < 5; i++) press(4'd3, 4'd9, 3 + i, $sformatf("lose_press%0d", i));
  endtask

  task automatic test_win();
    do_new_game("win");
    for (int i = 0; i < 4; i++) press(4'(i + 2), 4'(i + 2), 4, $sformatf("win_press%0d", i));
    do_new_game("win_restart");
  endtask

  task automatic test_hold();
    do_new_game("hold");
    press(4'd7, 4'd7, 50, "hold_long");
    press(4'd7, 4'd1, 3, "hold_second");
  endtask

  task automatic test_held_through_reset();
    int h0, mi0, n0;
    bus.submit = 1'b1; bus.guess = 4'd2; bus.target = 4'd2;
    rst_n = 1'b0;
    repeat (2) wait_edge();
    rst_n = 1'b1;
    model_clear();
    h0 = hit_cnt; mi0 = miss_cnt; n0 = nreq_cnt;
    repeat (20) wait_edge();
    checks++;
    if (hit_cnt != h0 || miss_cnt != mi0 || nreq_cnt != n0 || bus.right !== 3'd0) begin
      failures++;
      $display("FAIL held_reset: got %0d judgments right=%0d, want 0 0",
               (hit_cnt - h0) + (miss_cnt - mi0), bus.right);
    end
    bus.submit = 1'b0;
    repeat (4) wait_edge();
    press(4'd2, 4'd2, 3, "held_reset_repress");
  endtask

  task automatic test_new_game_vs_judge();
    int h0, n0;
    do_new_game("ng_judge");
    press(4'd1, 4'd1, 3, "ng_setup1");
    press(4'd4, 4'd4, 3, "ng_setup2");
    h0 = hit_cnt; n0 = nreq_cnt;
    bus.guess = 4'd6; bus.target = 4'd6; bus.submit = 1'b1;
    repeat (3) wait_edge();
    bus.new_game = 1'b1;
    wait_edge();
    bus.new_game = 1'b0;
    bus.submit = 1'b0;
    model_clear();
    repeat (4) wait_edge();
    checks++;
    if (hit_cnt != h0 || nreq_cnt - n0 != 1 || bus.right !== 3'd0) begin
      failures++;
      $display("FAIL ng_judge: got hit=%0d next_req=%0d right=%0d, want 0 1 0",
               hit_cnt - h0, nreq_cnt - n0, bus.right);
    end
  endtask

  task automatic test_reset_mid_judge();
    int n0;
    press(4'd8, 4'd8, 3, "rst_setup");
    bus.guess = 4'd3; bus.target = 4'd3; bus.submit = 1'b1;
    repeat (3) wait_edge();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.right, bus.wrong, bus.hit, bus.miss, bus.next_req, bus.game_over, bus.win} !== 11'd0) begin
      failures++;
      $display("FAIL rst_mid_judge: got %b, want all 0",
               {bus.right, bus.wrong, bus.hit, bus.miss, bus.next_req, bus.game_over, bus.win});
    end
    n0 = nreq_cnt;
    bus.submit = 1'b0;
    repeat (2) wait_edge();
    rst_n = 1'b1;
    model_clear();
    repeat (4) wait_edge();
    checks++;
    if (nreq_cnt != n0 || bus.right !== 3'd0) begin
      failures++;
      $display("FAIL rst_mid_judge_after: got next_req=%0d right=%0d, want 0 0", nreq_cnt - n0, bus.right);
    end
  endtask

  task automatic test_random();
    do_new_game("rand");
    for (int i = 0; i < 40; i++) begin
      if (m_over && $urandom_range(0, 1) == 1) do_new_game($sformatf("rand_ng%0d", i));
      press(4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), $urandom_range(3, 8),
            $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    model_clear();
    test_reset();
    test_latency();
    check_state("latency_state");
    test_lose();
    test_win();
    test_hold();
    test_held_through_reset();
    test_new_game_vs_judge();
    test_reset_mid_judge();
    test_random();
    checks++;
    if (dbl_cnt != 0) begin
      failures++;
      $display("FAIL pulse_width: got %0d multi-cycle pulses, want 0", dbl_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
